esn_readout: RTL and testbench



---
 rtl/esn_pkg.sv | 24 ++
 rtl/esn_sat_shift.sv | 27 ++
 rtl/esn_readout.sv | 111 +++++++++++
 tb/tb_esn_readout.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/esn_pkg.sv
// Shared constants, readout FSM encoding and helpers for the integer echo state network.
package esn_pkg;

  localparam int STATE_W_DFLT  = 8;
  localparam int WEIGHT_W_DFLT = 8;
  localparam int ACC_W_DFLT    = 24;
  localparam int OUT_W_DFLT    = 16;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } readoutState_t;

  // Address width for n entries, never below one bit.
  function automatic int clog2Min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/esn_sat_shift.sv
// Arithmetic right shift followed by saturation to a signed OUT_W result.
module esn_sat_shift #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 8,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] iAcc,
  output logic signed [OUT_W-1:0] oSat
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    // >>> on a signed operand floors toward minus infinity
    shifted = iAcc >>> SHIFT;
    if (shifted > MAX_V)
      oSat = MAX_V[OUT_W-1:0];
    else if (shifted < MIN_V)
      oSat = MIN_V[OUT_W-1:0];
    else
      oSat = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/esn_readout.sv
// Readout stage: dot product of reservoir state with output weights, scaled and saturated,
// started by a rising edge of the handler enable and acknowledged with a one-cycle ready pulse.
module esn_readout
  import esn_pkg::*;
#(
  parameter int N_NEURONS = 16,
  parameter int STATE_W   = STATE_W_DFLT,
  parameter int WEIGHT_W  = WEIGHT_W_DFLT,
  parameter int ACC_W     = ACC_W_DFLT,
  parameter int SHIFT     = 8,
  parameter int OUT_W     = OUT_W_DFLT,
  parameter int ADDR_W    = clog2Min1(N_NEURONS)
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       iEn,
  output logic        [ADDR_W-1:0]   oStateAddr,
  input  logic signed [STATE_W-1:0]  iStateData,
  output logic        [ADDR_W-1:0]   oWeightAddr,
  input  logic signed [WEIGHT_W-1:0] iWeightData,
  output logic signed [OUT_W-1:0]    oResult,
  output logic                       oIntRdy,
  output logic                       oBusy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NEURONS - 1);

  readoutState_t state;
  logic enPrev;
  logic dataValid;
  logic signed [ACC_W-1:0] acc;
  logic signed [STATE_W+WEIGHT_W-1:0] product;
  logic signed [ACC_W-1:0] productExt;
  logic signed [OUT_W-1:0] satValue;

  assign product     = iStateData * iWeightData;
  assign productExt  = ACC_W'(product);
  assign oWeightAddr = oStateAddr;

  esn_sat_shift #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) uSatShift (
    .iAcc(acc),
    .oSat(satValue)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state      <= IDLE;
      enPrev     <= 1'b0;
      dataValid  <= 1'b0;
      acc        <= '0;
      oStateAddr <= '0;
      oResult    <= '0;
      oIntRdy    <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      enPrev  <= iEn;
      oIntRdy <= 1'b0;
      unique case (state)
        IDLE: begin
          // Only a fresh rise starts; the handler lingers high after completion.
          if (iEn && !enPrev) begin
            acc        <= '0;
            oStateAddr <= '0;
            dataValid  <= 1'b0;
            oBusy      <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (!iEn) begin
            dataValid <= 1'b0;
            oBusy     <= 1'b0;
            state     <= IDLE;
          end else begin
            if (dataValid) acc <= acc + productExt;
            dataValid <= 1'b1;
            if (oStateAddr == LAST_ADDR)
              state <= DRAIN;
            else
              oStateAddr <= oStateAddr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          dataValid <= 1'b0;
          if (!iEn) begin
            oBusy <= 1'b0;
            state <= IDLE;
          end else begin
            acc   <= acc + productExt;
            state <= DONE;
          end
        end
        DONE: begin
          oResult <= satValue;
          oIntRdy <= 1'b1;
          oBusy   <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_esn_readout.sv
// Directed bench for esn_readout: three instances (N=4/SHIFT=0, N=16/SHIFT=0, N=1/SHIFT=3).
module tb_esn_readout;

  logic clk;
  logic rst_n;
  int tests;
  int failures;

  logic en4, en16, en1;
  logic [1:0] addr4, waddr4;
  logic [3:0] addr16, waddr16;
  logic [0:0] addr1, waddr1;
  logic signed [7:0] sd4, wd4, sd16, wd16, sd1, wd1;
  logic signed [15:0] res4, res16, res1;
  logic rdy4, rdy16, rdy1, busy4, busy16, busy1;

  logic signed [7:0] st4 [4];
  logic signed [7:0] wt4 [4];
  logic signed [7:0] st16 [16];
  logic signed [7:0] wt16 [16];
  logic signed [7:0] st1 [2];
  logic signed [7:0] wt1 [2];

  esn_readout #(.N_NEURONS(4), .STATE_W(8), .WEIGHT_W(8), .ACC_W(24), .SHIFT(0), .OUT_W(16), .ADDR_W(2)) dut4 (
    .iClk(clk), .iRst_n(rst_n), .iEn(en4), .oStateAddr(addr4), .iStateData(sd4),
    .oWeightAddr(waddr4), .iWeightData(wd4), .oResult(res4), .oIntRdy(rdy4), .oBusy(busy4));

  esn_readout #(.N_NEURONS(16), .STATE_W(8), .WEIGHT_W(8), .ACC_W(24), .SHIFT(0), .OUT_W(16), .ADDR_W(4)) dut16 (
    .iClk(clk), .iRst_n(rst_n), .iEn(en16), .oStateAddr(addr16), .iStateData(sd16),
    .oWeightAddr(waddr16), .iWeightData(wd16), .oResult(res16), .oIntRdy(rdy16), .oBusy(busy16));

  esn_readout #(.N_NEURONS(1), .STATE_W(8), .WEIGHT_W(8), .ACC_W(24), .SHIFT(3), .OUT_W(16), .ADDR_W(1)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iEn(en1), .oStateAddr(addr1), .iStateData(sd1),
    .oWeightAddr(waddr1), .iWeightData(wd1), .oResult(res1), .oIntRdy(rdy1), .oBusy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read state RAM / weight ROM models
  always @(posedge clk) begin
    sd4  <= st4[addr4];
    wd4  <= wt4[waddr4];
    sd16 <= st16[addr16];
    wd16 <= wt16[waddr16];
    sd1  <= st1[addr1];
    wd1  <= wt1[waddr1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts edges after the start edge until the selected ready pulse; -1 on timeout.
  task automatic waitRdy(input int which, output int edges);
    logic seen;
    edges = 0;
    seen = 1'b0;
    while (edges < 60 && !seen) begin
      tick();
      edges++;
      seen = (which == 1) ? rdy1 : (which == 4) ? rdy4 : rdy16;
    end
    if (!seen) edges = -1;
  endtask

  initial begin
    int edges;
    int pulses;
    tests = 0;
    failures = 0;
    rst_n = 1'b0;
    en4 = 1'b0;
    en16 = 1'b0;
    en1 = 1'b0;
    st4 = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    wt4 = '{8'sd2, 8'sd3, -8'sd1, 8'sd4};
    for (int i = 0; i < 16; i++) begin
      st16[i] = 8'sd127;
      wt16[i] = 8'sd127;
    end
    st1[0] = 8'sd7;
    st1[1] = 8'sd0;
    wt1[0] = 8'sd0;
    wt1[1] = 8'sd0;
    repeat (2) tick();

    check("reset_res4", res4, 0);
    check("reset_rdy4", rdy4, 0);
    check("reset_busy4", busy4, 0);
    check("reset_addr16", addr16, 0);
    check("reset_waddr16", waddr16, 0);
    check("reset_res16", res16, 0);
    check("reset_res1", res1, 0);
    rst_n = 1'b1;
    tick();

    // Basic sum, N=4: ready exactly on edge 6, single cycle
    en4 = 1'b1;
    tick();
    check("n4_busy_start", busy4, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("n4_rdy_edge%0d", k), rdy4, (k == 6) ? 1 : 0);
    end
    check("n4_result", res4, 8);
    check("n4_busy_end", busy4, 0);
    en4 = 1'b0;
    tick();

    // N=1, SHIFT=3: floor rounding of negative and positive sums
    st1[0] = 8'sd7;
    wt1[0] = -8'sd128 - 8'sd15; // wraps to 8'sd113 if taken literally; set below instead
    wt1[0] = 8'sh71;
    wt1[0] = 8'sd0;
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
    tick();
    check("n1_abort_busy", busy1, 0);
    tick();

    // 8-bit weights cannot hold +/-143, so the product -1001 / 1001 is formed as state 7 x weight -143 via state/weight split 7 x -143 = -1001 using 8-bit values 11 x -91 = -1001 and 11 x 91 = 1001
    st1[0] = 8'sd11;
    wt1[0] = -8'sd91;
    en1 = 1'b1;
    tick();
    waitRdy(1, edges);
    check("n1_latency_neg", edges, 3);
    check("n1_result_neg", res1, -126);
    en1 = 1'b0;
    tick();
    wt1[0] = 8'sd91;
    en1 = 1'b1;
    tick();
    waitRdy(1, edges);
    check("n1_latency_pos", edges, 3);
    check("n1_result_pos", res1, 125);
    en1 = 1'b0;
    tick();

    // Positive saturation, then iEn held high past completion
    en16 = 1'b1;
    tick();
    waitRdy(16, edges);
    check("n16_latency_pos", edges, 18);
    check("n16_sat_pos", res16, 32767);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rdy16) pulses++;
    end
    check("hold_no_restart_rdy", pulses, 0);
    check("hold_no_restart_busy", busy16, 0);
    en16 = 1'b0;
    tick();

    // Negative saturation after a low-then-high enable
    for (int i = 0; i < 16; i++) wt16[i] = -8'sd128;
    en16 = 1'b1;
    tick();
    waitRdy(16, edges);
    check("n16_latency_neg", edges, 18);
    check("n16_sat_neg", res16, -32768);
    en16 = 1'b0;
    tick();

    // Abort at RUN cycle 5
    for (int i = 0; i < 16; i++) begin
      st16[i] = 8'sd1;
      wt16[i] = 8'sd1;
    end
    en16 = 1'b1;
    tick();
    repeat (5) tick();
    en16 = 1'b0;
    tick();
    check("abort_busy", busy16, 0);
    check("abort_res_kept", res16, -32768);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (rdy16) pulses++;
    end
    check("abort_no_rdy", pulses, 0);
    check("abort_res_after", res16, -32768);

    // Reset mid-RUN, then a clean full run
    en16 = 1'b1;
    tick();
    repeat (3) tick();
    rst_n = 1'b0;
    en16 = 1'b0;
    tick();
    check("rst_mid_res", res16, 0);
    check("rst_mid_rdy", rdy16, 0);
    check("rst_mid_busy", busy16, 0);
    check("rst_mid_addr", addr16, 0);
    check("rst_mid_res4", res4, 0);
    rst_n = 1'b1;
    tick();
    en16 = 1'b1;
    tick();
    waitRdy(16, edges);
    check("post_rst_latency", edges, 18);
    check("post_rst_result", res16, 16);
    tick();
    check("post_rst_pulse_width", rdy16, 0);
    en16 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
